// File: rtl/fb_bus_responder.sv
// ============================================================================
// Module   : fb_bus_responder
// Brief    : fb_cpu bus responder - RAM with 1-cycle registered read, MMIO
//            window (switches, LEDs, timer, status) and a side-band loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_bus_responder #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int IO_BASE       = 60,
  parameter int TIMER_DIV     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_ram_data_in,
  output logic [DATA_WIDTH-1:0]    o_ram_data_out,
  input  logic [DATA_WIDTH-1:0]    switches,
  output logic [DATA_WIDTH-1:0]    leds,
  input  logic                     ld_valid,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_ready
);

  // One spare address bit so MMIO slots beyond the address space never match.
  localparam int AXW = ADDRESS_WIDTH + 1;
  localparam int PW  = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  localparam logic [AXW-1:0] A_SW   = AXW'(IO_BASE);
  localparam logic [AXW-1:0] A_LED  = AXW'(IO_BASE + 1);
  localparam logic [AXW-1:0] A_TMR  = AXW'(IO_BASE + 2);
  localparam logic [AXW-1:0] A_STAT = AXW'(IO_BASE + 3);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TIMER_DIV - 1);

  logic [DATA_WIDTH-1:0] mem [IO_BASE];

  logic [AXW-1:0]        addr_x;
  logic [AXW-1:0]        ld_addr_x;
  logic                  ram_sel;
  logic                  ld_ram_sel;
  logic                  led_wr;
  logic                  tmr_wr;
  logic                  stat_wr;
  logic                  tick;
  logic                  tmr_wrap;
  logic [DATA_WIDTH-1:0] rd_next;

  logic [DATA_WIDTH-1:0] sw_s1;
  logic [DATA_WIDTH-1:0] sw_s2;
  logic [DATA_WIDTH-1:0] timer;
  logic [PW-1:0]         presc;
  logic                  ovf;

  assign addr_x     = {1'b0, i_addr};
  assign ld_addr_x  = {1'b0, ld_addr};
  assign ram_sel    = (addr_x < A_SW);
  assign ld_ram_sel = (ld_addr_x < A_SW);

  assign led_wr   = i_we && (addr_x == A_LED);
  assign tmr_wr   = i_we && (addr_x == A_TMR);
  assign stat_wr  = i_we && (addr_x == A_STAT);
  assign tick     = (presc == PRESC_MAX);
  // A CPU timer write at the same edge suppresses both increment and overflow.
  assign tmr_wrap = tick && !tmr_wr && (timer == {DATA_WIDTH{1'b1}});

  assign ld_ready = rst && !i_we;

  always_comb begin
    rd_next = '0;
    if (ram_sel)
      rd_next = mem[i_addr];
    else if (addr_x == A_SW)
      rd_next = sw_s2;
    else if (addr_x == A_LED)
      rd_next = leds;
    else if (addr_x == A_TMR)
      rd_next = timer;
    else if (addr_x == A_STAT)
      rd_next = {{(DATA_WIDTH-1){1'b0}}, ovf};
  end

  // RAM is deliberately outside the reset domain so images survive a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (i_we && ram_sel)
        mem[i_addr] <= i_ram_data_in;
      else if (ld_valid && ld_ready && ld_ram_sel)
        mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ram_data_out <= '0;
      leds           <= '0;
      sw_s1          <= '0;
      sw_s2          <= '0;
      timer          <= '0;
      presc          <= '0;
      ovf            <= 1'b0;
    end else begin
      o_ram_data_out <= rd_next;
      sw_s1          <= switches;
      sw_s2          <= sw_s1;

      if (led_wr)
        leds <= i_ram_data_in;

      if (tmr_wr) begin
        timer <= i_ram_data_in;
        presc <= '0;
      end else if (tick) begin
        timer <= timer + DATA_WIDTH'(1);
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      // Set beats write-1-to-clear so a coincident overflow is never lost.
      if (tmr_wrap)
        ovf <= 1'b1;
      else if (stat_wr && i_ram_data_in[0])
        ovf <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_bus_responder.sv
// ============================================================================
// Module   : tb_fb_bus_responder
// Brief    : Self-checking bench for fb_bus_responder against a memory-map model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_bus_responder;

  localparam int AW  = 6;
  localparam int DW  = 10;
  localparam int IOB = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_we = 1'b0;
  logic [AW-1:0] i_addr = AW'(62);
  logic [DW-1:0] i_ram_data_in = '0;
  logic [DW-1:0] o_ram_data_out;
  logic [DW-1:0] switches = '0;
  logic [DW-1:0] leds;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;

  fb_bus_responder dut (
    .clk            (clk),
    .rst            (rst),
    .i_we           (i_we),
    .i_addr         (i_addr),
    .i_ram_data_in  (i_ram_data_in),
    .o_ram_data_out (o_ram_data_out),
    .switches       (switches),
    .leds           (leds),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Behavioural view of the address map: array, two-deep switch history, counter.
  logic [DW-1:0] m_mem [IOB];
  logic [DW-1:0] m_leds, m_s1, m_s2;
  int            m_tmr;
  logic          m_ovf;

  function automatic logic [DW-1:0] m_read(input int a);
    if (a < IOB) return m_mem[a];
    case (a - IOB)
      0:       return m_s2;
      1:       return m_leds;
      2:       return DW'(m_tmr);
      3:       return DW'(m_ovf);
      default: return '0;
    endcase
  endfunction

  task automatic m_edge(input logic we, input int a, input logic [DW-1:0] d,
                        input logic lv, input int la, input logic [DW-1:0] ldd);
    if (we) begin
      if (a < IOB) m_mem[a] = d;
      else if (a == IOB + 1) m_leds = d;
      else if (a == IOB + 2) m_tmr = int'(d);
      else if (a == IOB + 3 && d[0]) m_ovf = 1'b0;
    end
    if (!(we && a == IOB + 2)) begin
      if (m_tmr == (1 << DW) - 1) m_ovf = 1'b1;
      m_tmr = (m_tmr + 1) % (1 << DW);
    end
    if (!we && lv && la < IOB) m_mem[la] = ldd;
    m_s2 = m_s1;
    m_s1 = switches;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic we, input int a, input logic [DW-1:0] d,
                      input logic lv, input int la, input logic [DW-1:0] ldd);
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    i_we = we; i_addr = AW'(a); i_ram_data_in = d;
    ld_valid = lv; ld_addr = AW'(la); ld_data = ldd;
    #1;
    chk("ld_ready", DW'(ld_ready), DW'(!we));
    exp_rd = m_read(a);
    @(posedge clk);
    m_edge(we, a, d, lv, la, ldd);
    #1;
    chk("rdata", o_ram_data_out, exp_rd);
    chk("leds", leds, m_leds);
  endtask

  // Releases reset with a TMR read pending, so the first edge exposes the timer.
  task automatic release_reset();
    @(negedge clk);
    i_we = 1'b0; ld_valid = 1'b0; i_addr = AW'(IOB + 2);
    rst = 1'b1;
    m_leds = '0; m_s1 = '0; m_s2 = '0; m_tmr = 0; m_ovf = 1'b0;
    @(posedge clk);
    m_edge(1'b0, IOB + 2, '0, 1'b0, 0, '0);
    #1;
    chk("tmr_after_reset", o_ram_data_out, '0);
  endtask

  initial begin
    logic [DW-1:0] img [6];
    int            img_a [6];
    img   = '{10'h032, 10'h0B3, 10'h074, 10'h240, 10'd5, 10'd10};
    img_a = '{0, 1, 2, 3, 50, 51};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", o_ram_data_out, '0);
    chk("reset_leds", leds, '0);
    chk("reset_ld_ready", DW'(ld_ready), '0);
    release_reset();

    // Program image plus random fill of the remaining RAM, all via the loader.
    for (int a = 0; a < IOB; a++)
      step(1'b0, IOB, '0, 1'b1, a, DW'($urandom));
    for (int i = 0; i < 6; i++)
      step(1'b0, IOB, '0, 1'b1, img_a[i], img[i]);
    for (int i = 0; i < 6; i++)
      step(1'b0, img_a[i], '0, 1'b0, 0, '0);

    // LED write then readback.
    step(1'b1, IOB + 1, 10'h2AA, 1'b0, 0, '0);
    step(1'b0, IOB + 1, '0, 1'b0, 0, '0);
    chk("leds_2aa", leds, 10'h2AA);

    // Switch synchronizer latency.
    switches = 10'h155;
    for (int i = 0; i < 4; i++)
      step(1'b0, IOB, '0, 1'b0, 0, '0);
    chk("sw_155", o_ram_data_out, 10'h155);

    // Timer overflow, W1C, and the two coincidence cases.
    step(1'b1, IOB + 2, 10'h3FE, 1'b0, 0, '0);
    step(1'b0, 0, '0, 1'b0, 0, '0);
    step(1'b0, 0, '0, 1'b0, 0, '0);
    step(1'b0, IOB + 2, '0, 1'b0, 0, '0);
    chk("tmr_wrapped", o_ram_data_out, '0);
    step(1'b0, IOB + 3, '0, 1'b0, 0, '0);
    chk("stat_set", o_ram_data_out, 10'd1);
    step(1'b1, IOB + 3, 10'd1, 1'b0, 0, '0);
    step(1'b0, IOB + 3, '0, 1'b0, 0, '0);
    step(1'b1, IOB + 2, 10'h3FF, 1'b0, 0, '0);
    step(1'b1, IOB + 3, 10'd1, 1'b0, 0, '0);
    step(1'b0, IOB + 3, '0, 1'b0, 0, '0);
    chk("stat_w1c_vs_ovf", o_ram_data_out, 10'd1);
    step(1'b1, IOB + 3, 10'd1, 1'b0, 0, '0);
    step(1'b1, IOB + 2, 10'h3FF, 1'b0, 0, '0);
    step(1'b1, IOB + 2, 10'h005, 1'b0, 0, '0);
    step(1'b0, IOB + 3, '0, 1'b0, 0, '0);
    step(1'b0, IOB + 2, '0, 1'b0, 0, '0);

    // CPU priority over the loader, then dropped MMIO loader write.
    step(1'b1, 5, 10'd7, 1'b1, 6, 10'd9);
    step(1'b0, 5, '0, 1'b1, 6, 10'd9);
    step(1'b0, 6, '0, 1'b0, 0, '0);
    step(1'b0, IOB + 1, '0, 1'b1, IOB + 1, 10'h0F0);
    step(1'b0, IOB + 1, '0, 1'b0, 0, '0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) switches = DW'($urandom);
      step($urandom_range(3) == 0, $urandom_range(63), DW'($urandom),
           1'($urandom), $urandom_range(63), DW'($urandom));
    end

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    step(1'b1, IOB + 1, 10'h3C3, 1'b0, 0, '0);
    step(1'b0, IOB + 1, '0, 1'b0, 0, '0);
    @(negedge clk);
    i_we = 1'b0; ld_valid = 1'b1; ld_addr = AW'(7); ld_data = ~m_mem[7];
    #2 rst = 1'b0;
    #1;
    chk("async_rdata", o_ram_data_out, '0);
    chk("async_leds", leds, '0);
    chk("async_ld_ready", DW'(ld_ready), '0);
    repeat (2) @(posedge clk);
    release_reset();
    for (int a = 0; a < IOB; a++)
      step(1'b0, a, '0, 1'b0, 0, '0);
    step(1'b0, IOB + 3, '0, 1'b0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
